// File: rtl/apb_arbiter_m2.sv
// Two-master APB3 arbiter sharing one downstream APB bus.
//
// Each requester port (S0_*, S1_*) acts as an APB3 completer toward its master;
// the shared bus (M_*) is driven with a clean SETUP/ACCESS sequence. Contests
// are settled round-robin, and a PREADY watchdog ends hung transfers with PSLVERR.
//
// Ports:
//   PCLK, PRESETn              clock (rising edge), asynchronous active-low reset
//   S0_*/S1_* PSEL/PENABLE/... requester-side APB inputs
//   S0_*/S1_* PRDATA/PREADY/PSLVERR  requester-side responses
//   M_*                        shared downstream APB bus
//   GRANT                      one-hot {S1,S0} grant, 2'b00 when idle
module apb_arbiter_m2 #(
  parameter int unsigned P_TIMEOUT = 255,  // ACCESS wait cycles before forced end; 0 disables
  parameter int unsigned P_TO_BITS = 8     // watchdog counter width
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        S0_PSEL,
  input  logic        S0_PENABLE,
  input  logic        S0_PWRITE,
  input  logic [31:0] S0_PADDR,
  input  logic [31:0] S0_PWDATA,
  output logic [31:0] S0_PRDATA,
  output logic        S0_PREADY,
  output logic        S0_PSLVERR,
  input  logic        S1_PSEL,
  input  logic        S1_PENABLE,
  input  logic        S1_PWRITE,
  input  logic [31:0] S1_PADDR,
  input  logic [31:0] S1_PWDATA,
  output logic [31:0] S1_PRDATA,
  output logic        S1_PREADY,
  output logic        S1_PSLVERR,
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [31:0] M_PADDR,
  output logic [31:0] M_PWDATA,
  input  logic [31:0] M_PRDATA,
  input  logic        M_PREADY,
  input  logic        M_PSLVERR,
  output logic [1:0]  GRANT
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  localparam bit WdEn = (P_TIMEOUT != 0);
  localparam logic [P_TO_BITS-1:0] ToLast =
    P_TO_BITS'((P_TIMEOUT == 0) ? 0 : P_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;     // index served most recently
  logic [P_TO_BITS-1:0] cnt_q, cnt_d;
  logic                 expire, done;

  // PENABLE from the masters carries no information for arbitration.
  logic unused_penable;
  assign unused_penable = S0_PENABLE ^ S1_PENABLE;

  assign expire = WdEn && (state_q == StAccess) && !M_PREADY && (cnt_q == ToLast);
  assign done   = (state_q == StAccess) && (M_PREADY || expire);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (S0_PSEL || S1_PSEL) begin
          state_d = StSetup;
          if (S0_PSEL && S1_PSEL) begin
            // Whoever was not served last wins the contest.
            grant_d = last_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = S0_PSEL ? 2'b01 : 2'b10;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (done) begin
          state_d = StIdle;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign M_PSEL    = (state_q != StIdle);
  assign M_PENABLE = (state_q == StAccess);
  assign GRANT     = grant_q;

  // Downstream request mux; grant only changes on the IDLE->SETUP edge.
  always_comb begin
    M_PWRITE = 1'b0;
    M_PADDR  = '0;
    M_PWDATA = '0;
    if (grant_q[0]) begin
      M_PWRITE = S0_PWRITE;
      M_PADDR  = S0_PADDR;
      M_PWDATA = S0_PWDATA;
    end else if (grant_q[1]) begin
      M_PWRITE = S1_PWRITE;
      M_PADDR  = S1_PADDR;
      M_PWDATA = S1_PWDATA;
    end
  end

  assign S0_PREADY  = grant_q[0] && done;
  assign S0_PSLVERR = S0_PREADY && (M_PSLVERR || expire);
  assign S0_PRDATA  = S0_PREADY ? M_PRDATA : '0;

  assign S1_PREADY  = grant_q[1] && done;
  assign S1_PSLVERR = S1_PREADY && (M_PSLVERR || expire);
  assign S1_PRDATA  = S1_PREADY ? M_PRDATA : '0;

endmodule

// File: tb/tb_apb_arbiter_m2.sv
// Testbench for apb_arbiter_m2: scoreboard of expected transfers built from
// service-order arithmetic, checked by an independent monitor.
module tb_apb_arbiter_m2;

  localparam int TO = 6;  // watchdog setting of the main instance

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          wcnt;   // ACCESS cycles with PREADY low before PREADY=1
    logic [31:0] rdata;
    logic        err;
  } slv_t;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } exp_t;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  logic PRESETn;

  logic [1:0]  s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [31:0] s_paddr [2];
  logic [31:0] s_pwdata [2];
  logic [31:0] s_prdata [2];
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic [1:0]  grant;

  apb_arbiter_m2 #(.P_TIMEOUT(TO), .P_TO_BITS(8)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .S0_PSEL(s_psel[0]), .S0_PENABLE(s_penable[0]), .S0_PWRITE(s_pwrite[0]),
    .S0_PADDR(s_paddr[0]), .S0_PWDATA(s_pwdata[0]), .S0_PRDATA(s_prdata[0]),
    .S0_PREADY(s_pready[0]), .S0_PSLVERR(s_pslverr[0]),
    .S1_PSEL(s_psel[1]), .S1_PENABLE(s_penable[1]), .S1_PWRITE(s_pwrite[1]),
    .S1_PADDR(s_paddr[1]), .S1_PWDATA(s_pwdata[1]), .S1_PRDATA(s_prdata[1]),
    .S1_PREADY(s_pready[1]), .S1_PSLVERR(s_pslverr[1]),
    .M_PSEL(m_psel), .M_PENABLE(m_penable), .M_PWRITE(m_pwrite),
    .M_PADDR(m_paddr), .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata),
    .M_PREADY(m_pready), .M_PSLVERR(m_pslverr), .GRANT(grant)
  );

  // Watchdog instances: index 0 has P_TIMEOUT=4, index 1 has the watchdog off.
  logic        wd_psel;
  logic [1:0]  wd_s0_pready, wd_s0_pslverr, wd_s1_pready, wd_s1_pslverr;
  logic [1:0]  wd_m_psel, wd_m_penable, wd_m_pwrite;
  logic [31:0] wd_s0_prdata [2];
  logic [31:0] wd_s1_prdata [2];
  logic [31:0] wd_m_paddr [2];
  logic [31:0] wd_m_pwdata [2];
  logic [1:0]  wd_grant [2];

  for (genvar g = 0; g < 2; g++) begin : g_wd
    apb_arbiter_m2 #(.P_TIMEOUT((g == 0) ? 4 : 0), .P_TO_BITS(8)) u_wd (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .S0_PSEL(wd_psel), .S0_PENABLE(1'b0), .S0_PWRITE(1'b0),
      .S0_PADDR(32'h0000_0040), .S0_PWDATA(32'h0), .S0_PRDATA(wd_s0_prdata[g]),
      .S0_PREADY(wd_s0_pready[g]), .S0_PSLVERR(wd_s0_pslverr[g]),
      .S1_PSEL(1'b0), .S1_PENABLE(1'b0), .S1_PWRITE(1'b0),
      .S1_PADDR(32'h0), .S1_PWDATA(32'h0), .S1_PRDATA(wd_s1_prdata[g]),
      .S1_PREADY(wd_s1_pready[g]), .S1_PSLVERR(wd_s1_pslverr[g]),
      .M_PSEL(wd_m_psel[g]), .M_PENABLE(wd_m_penable[g]), .M_PWRITE(wd_m_pwrite[g]),
      .M_PADDR(wd_m_paddr[g]), .M_PWDATA(wd_m_pwdata[g]), .M_PRDATA(32'h0),
      .M_PREADY(1'b0), .M_PSLVERR(1'b0), .GRANT(wd_grant[g])
    );
  end

  exp_t exp_q [$];
  slv_t slv_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   model_last = 1;  // index served most recently, per the reference model
  bit   mon_en = 1'b1;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic int eff_wait(input int w);
    return (w >= TO) ? TO - 1 : w;
  endfunction

  function automatic logic [1:0] onehot(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic exp_t mk_exp(input int idx, input req_t r, input slv_t s, input int d);
    exp_t e;
    e.idx      = idx;
    e.addr     = r.addr;
    e.wr       = r.wr;
    e.wdata    = r.wdata;
    e.rdata    = s.rdata;
    e.err      = (s.wcnt >= TO) ? 1'b1 : s.err;
    e.done_cyc = d;
    return e;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.addr  = $urandom;
    r.wr    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    return r;
  endfunction

  function automatic slv_t rnd_slv();
    slv_t s;
    s.wcnt  = $urandom_range(0, 8);
    s.rdata = $urandom;
    s.err   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Master BFM: hold the request until PREADY, then release after the edge.
  task automatic master_wait(input int m);
    bit got = 1'b0;
    @(posedge PCLK); #1 s_penable[m] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (s_pready[m]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL master%0d_timeout: PREADY=0 for 40 cycles, want PREADY=1", m);
    end
    @(posedge PCLK); #1;
    s_psel[m]    = 1'b0;
    s_penable[m] = 1'b0;
  endtask

  // One round: the masters in req raise PSEL together from an idle bus.
  // sa/sb are the slave behaviours for the first and second transfer served.
  task automatic run_round(input bit [1:0] req, input req_t r0, input req_t r1,
                           input slv_t sa, input slv_t sb);
    int   first, second, start, d1;
    req_t rq [2];
    rq[0] = r0;
    rq[1] = r1;
    if (req == 2'b11) first = (model_last == 1) ? 0 : 1;
    else              first = req[1] ? 1 : 0;
    second = 1 - first;
    @(negedge PCLK);
    start = cyc;
    d1    = start + 2 + eff_wait(sa.wcnt);
    exp_q.push_back(mk_exp(first, rq[first], sa, d1));
    slv_q.push_back(sa);
    model_last = first;
    if (req == 2'b11) begin
      exp_q.push_back(mk_exp(second, rq[second], sb, d1 + 3 + eff_wait(sb.wcnt)));
      slv_q.push_back(sb);
      model_last = second;
    end
    for (int m = 0; m < 2; m++) begin
      if (req[m]) begin
        s_psel[m]    = 1'b1;
        s_penable[m] = 1'b0;
        s_paddr[m]   = rq[m].addr;
        s_pwrite[m]  = rq[m].wr;
        s_pwdata[m]  = rq[m].wdata;
      end
    end
    fork
      if (req[0]) master_wait(0);
      if (req[1]) master_wait(1);
    join
  endtask

  // Downstream slave: takes its behaviour from slv_q at each SETUP; drives
  // random junk on PREADY/PSLVERR whenever they must be ignored.
  initial begin : slave
    slv_t cur;
    int   i;
    cur.wcnt = 1000; cur.rdata = 0; cur.err = 0;
    i = 0;
    m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = '0;
    forever begin
      @(posedge PCLK); #1;
      if (m_psel && !m_penable) begin
        if (slv_q.size() > 0) cur = slv_q.pop_front();
        else begin
          cur.wcnt = 1000; cur.rdata = $urandom; cur.err = 1'b0;
        end
        i = 0;
        m_prdata  = $urandom;
        m_pready  = 1'($urandom_range(0, 1));
        m_pslverr = 1'($urandom_range(0, 1));
      end else if (m_psel && m_penable) begin
        i++;
        m_prdata  = cur.rdata;
        m_pready  = (i > cur.wcnt);
        m_pslverr = m_pready ? cur.err : 1'($urandom_range(0, 1));
      end else begin
        m_prdata  = $urandom;
        m_pready  = 1'($urandom_range(0, 1));
        m_pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: checks the downstream request at SETUP and pops on every PREADY.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && mon_en) begin
        if (m_psel && !m_penable) begin
          if (exp_q.size() == 0) chk("setup_unexpected", 32'(m_psel), 32'h0);
          else begin
            e = exp_q[0];
            chk("grant_setup", 32'(grant), 32'(onehot(e.idx)));
            chk("m_paddr", m_paddr, e.addr);
            chk("m_pwrite", 32'(m_pwrite), 32'(e.wr));
            chk("m_pwdata", m_pwdata, e.wdata);
          end
        end
        if (s_pready != 2'b00) begin
          if (exp_q.size() == 0) chk("pready_unexpected", 32'(s_pready), 32'h0);
          else begin
            e = exp_q.pop_front();
            chk("pready_who", 32'(s_pready), 32'(onehot(e.idx)));
            chk("grant_access", 32'(grant), 32'(onehot(e.idx)));
            chk("prdata", s_prdata[e.idx], e.rdata);
            chk("pslverr", 32'(s_pslverr), e.err ? 32'(onehot(e.idx)) : 32'h0);
            chk("prdata_other", s_prdata[1 - e.idx], 32'h0);
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_psel"}, 32'(m_psel), 32'h0);
    chk({tag, "_m_penable"}, 32'(m_penable), 32'h0);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_m_paddr"}, m_paddr, 32'h0);
    chk({tag, "_m_pwrite"}, 32'(m_pwrite), 32'h0);
    chk({tag, "_m_pwdata"}, m_pwdata, 32'h0);
    chk({tag, "_s_pready"}, 32'(s_pready), 32'h0);
    chk({tag, "_s_pslverr"}, 32'(s_pslverr), 32'h0);
    chk({tag, "_s0_prdata"}, s_prdata[0], 32'h0);
    chk({tag, "_s1_prdata"}, s_prdata[1], 32'h0);
  endtask

  initial begin : global_bound
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want $finish");
    $fatal(1);
  end

  initial begin : stim
    req_t r0, r1;
    slv_t sa, sb;
    int   n;
    PRESETn = 1'b0;
    wd_psel = 1'b0;
    s_psel = '0; s_penable = '0; s_pwrite = '0;
    for (int m = 0; m < 2; m++) begin
      s_paddr[m]  = $urandom;
      s_pwdata[m] = $urandom;
    end
    repeat (3) @(negedge PCLK);
    chk_all_zero("reset");
    PRESETn = 1'b1;

    // Single write from S0 with a zero-wait slave.
    r0.addr = 32'hC000_0004; r0.wr = 1'b1; r0.wdata = 32'hA5A5_0000;
    r1 = rnd_req();
    sa.wcnt = 0; sa.rdata = 32'h0; sa.err = 1'b0;
    sb = rnd_slv();
    run_round(2'b01, r0, r1, sa, sb);

    // S1 read with five wait states and an error response.
    r1.addr = 32'h0000_1000; r1.wr = 1'b0; r1.wdata = 32'h0;
    sa.wcnt = 5; sa.rdata = 32'h1234_5678; sa.err = 1'b1;
    run_round(2'b10, r0, r1, sa, sb);

    // Contest: S0 reads, S1 writes; S1 was served last so S0 goes first.
    r0.addr = 32'h0000_0200; r0.wr = 1'b0; r0.wdata = 32'h0;
    r1.addr = 32'h0000_0300; r1.wr = 1'b1; r1.wdata = 32'hDEAD_BEEF;
    sa.wcnt = 0; sa.rdata = 32'h0BAD_F00D; sa.err = 1'b0;
    sb.wcnt = 0; sb.rdata = 32'h0;         sb.err = 1'b0;
    run_round(2'b11, r0, r1, sa, sb);

    // Continuous load: four back-to-back contests, zero-wait slave.
    for (int k = 0; k < 4; k++) begin
      sa = rnd_slv(); sa.wcnt = 0;
      sb = rnd_slv(); sb.wcnt = 0;
      run_round(2'b11, rnd_req(), rnd_req(), sa, sb);
    end

    // Randomised rounds, including watchdog expiries on the main instance.
    for (int k = 0; k < 40; k++) begin
      run_round(2'($urandom_range(1, 3)), rnd_req(), rnd_req(), rnd_slv(), rnd_slv());
      n = $urandom_range(0, 2);
      repeat (n) @(negedge PCLK);
    end

    // Watchdog: P_TIMEOUT=4 ends in the 4th ACCESS cycle; P_TIMEOUT=0 never does.
    @(negedge PCLK);
    wd_psel = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge PCLK);
      chk($sformatf("wd4_pready_c%0d", k), 32'(wd_s0_pready[0]), (k == 5) ? 32'h1 : 32'h0);
      chk($sformatf("wd4_pslverr_c%0d", k), 32'(wd_s0_pslverr[0]), (k == 5) ? 32'h1 : 32'h0);
    end
    @(negedge PCLK);
    wd_psel = 1'b0;
    chk("wd4_m_psel_after", 32'(wd_m_psel[0]), 32'h0);
    n = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (wd_s0_pready[1] || !wd_m_penable[1]) n++;
    end
    chk("wd0_still_waiting", 32'(n), 32'h0);

    // Reset during ACCESS, with S0 served last so S1 would otherwise win next.
    run_round(2'b01, rnd_req(), rnd_req(), rnd_slv(), rnd_slv());
    @(negedge PCLK);
    mon_en = 1'b0;
    s_psel[0] = 1'b1;
    s_paddr[0] = 32'h5555_0000;
    @(posedge PCLK);
    @(posedge PCLK); #3;
    PRESETn = 1'b0;
    #1;
    chk_all_zero("midreset");
    s_psel = '0; s_penable = '0;
    model_last = 1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    mon_en = 1'b1;
    sa.wcnt = 1; sa.rdata = 32'hCAFE_0001; sa.err = 1'b0;
    sb.wcnt = 2; sb.rdata = 32'hCAFE_0002; sb.err = 1'b0;
    run_round(2'b11, rnd_req(), rnd_req(), sa, sb);

    repeat (5) @(negedge PCLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
